ifu_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the 2-read/1-write simulation RAM.
- Drives the instruction-side read port (imem_en, imem_addr) and captures the returned instruction word.
- Buffers {pc, inst} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts redirects from execute and flags misaligned redirect targets as fetch exceptions.

---
 rtl/ifu_fetch_pkg.sv | 32 +++
 rtl/ifu_fetch_queue.sv | 79 +++++++
 rtl/ifu_fetch.sv | 138 +++++++++++++
 tb/tb_ifu_fetch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: types and constants shared by the instruction fetch stage.
//   XLEN      - address / PC width, matches the RAM port width
//   INST_W    - instruction width captured from the RAM read data
//   RESET_PC  - first fetch address after reset (RAM base)
//   fetch_state_e - fetch control states
//   fetch_entry_t - one {pc, inst, exc} queue entry
package ifu_fetch_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned INST_W   = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    StRun,
    StExcPend,
    StHalt
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              exc;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Instruction addresses must be 4-byte aligned.
  function automatic logic pc_aligned(input logic [XLEN-1:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: Depth-entry synchronous circular FIFO for fetch entries.
//   clk, rst_n   - clock, synchronous active-low reset
//   push, wdata  - enqueue one entry at the clock edge
//   pop          - dequeue the head entry at the clock edge
//   flush        - empty the queue; wins over push and pop
//   rdata        - head entry (registered storage, valid when !empty)
//   full, empty, count - occupancy
// Push together with pop while full is legal: occupancy stays the same.
module ifu_fetch_queue
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [CntW-1:0]    count
);

  logic [ENTRY_W-1:0] mem_q [Depth];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through the head when !empty.
  always_ff @(posedge clk) begin
    if (rst_n && push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_comb begin
    rdata = mem_q[rd_ptr_q];
    full  = (count_q == CntW'(Depth));
    empty = (count_q == '0);
    count = count_q;
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding decode from the instruction RAM port.
//   clk, rst_n          - clock, synchronous active-low reset
//   imem_en, imem_addr  - RAM instruction read port; imem_addr is always the PC
//   imem_data           - RAM read data, same cycle; only [31:0] is used
//   redirect_valid/_pc  - PC redirect from execute; flushes the queue
//   out_valid/out_ready - handshake toward decode
//   out_pc/inst/exc     - head entry; all zero while the queue is empty
// A misaligned redirect target produces a single exception marker entry and then
// fetch halts until the next redirect.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_en,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_exc
);

  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic fetch;
  logic exc_push;
  logic pop;
  logic q_full, q_empty;
  logic [ENTRY_W-1:0] q_wdata, q_rdata;
  fetch_entry_t wr_entry, head;

  logic [CntW-1:0] unused_count;
  logic            unused_data_hi;

  assign unused_data_hi = ^imem_data[XLEN-1:INST_W];

  // ---------------------------------------------------------------------------
  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. A redirect overrides everything else in every state.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = pc_aligned(redirect_pc) ? StRun : StExcPend;
    end else begin
      unique case (state_q)
        StRun:     state_d = StRun;
        StExcPend: state_d = StHalt;
        StHalt:    state_d = StHalt;
        default:   state_d = StRun;
      endcase
    end
  end

  // FSM: outputs. Fetch may refill a full queue when the head leaves this cycle.
  always_comb begin
    fetch    = 1'b0;
    exc_push = 1'b0;
    unique case (state_q)
      StRun:     fetch    = rst_n && !redirect_valid && (!q_full || pop);
      StExcPend: exc_push = rst_n && !redirect_valid;
      default:   ;
    endcase
    imem_en = fetch;
  end

  // ---------------------------------------------------------------------------
  // Program counter
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (fetch) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr = pc_q;

  // ---------------------------------------------------------------------------
  // Queue write entry: fetched word, or the misaligned-target marker.
  always_comb begin
    wr_entry.pc   = pc_q;
    wr_entry.inst = fetch ? imem_data[INST_W-1:0] : '0;
    wr_entry.exc  = !fetch;
    q_wdata       = wr_entry;
  end

  ifu_fetch_queue #(
    .Depth (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch || exc_push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (unused_count)
  );

  // Outputs are forced quiet while reset is asserted, whatever the queue holds.
  always_comb begin
    head      = q_rdata;
    out_valid = rst_n && !q_empty;
    pop       = out_valid && out_ready;
    out_pc    = out_valid ? head.pc   : '0;
    out_inst  = out_valid ? head.inst : '0;
    out_exc   = out_valid ? head.exc  : 1'b0;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus random traffic, every cycle checked
// against a queue-level reference model of the fetch stage.
module tb_ifu_fetch;

  localparam int QD = 2;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_en;
  logic [63:0] imem_addr;
  logic [63:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_exc;

  always #5 clk = ~clk;

  ifu_fetch #(
    .QDEPTH (QD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_exc        (out_exc)
  );

  // RAM contents: two known words at the base, a scrambled word elsewhere.
  function automatic logic [31:0] ram_inst(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0000_0013;
    if (a == 64'h8000_0004) return 32'h0010_0093;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  assign imem_data = {~imem_addr[31:0], ram_inst(imem_addr)};

  // Reference model: queue of delivered-order entries, PC, and fetch mode.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        exc;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] mpc = RST_PC;
  int          mmode = 0;  // 0 fetching, 1 marker pending, 2 halted

  int checks = 0;
  int failures = 0;

  logic        o_en, o_valid, o_exc;
  logic [63:0] o_addr, o_pc;
  logic [31:0] o_inst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy);
    logic exp_valid, exp_pop, exp_en;
    ent_t h;
    rst_n = r;
    redirect_valid = rv;
    redirect_pc = rpc;
    out_ready = rdy;
    @(negedge clk);
    o_en = imem_en; o_addr = imem_addr; o_valid = out_valid;
    o_pc = out_pc; o_inst = out_inst; o_exc = out_exc;
    exp_valid = r && (mq.size() > 0);
    exp_pop   = exp_valid && rdy;
    exp_en    = r && (mmode == 0) && !rv && ((mq.size() < QD) || exp_pop);
    if (exp_valid) h = mq[0];
    else h = '{pc: 64'h0, inst: 32'h0, exc: 1'b0};
    chk("imem_en", {63'h0, o_en}, {63'h0, exp_en});
    if (r) chk("imem_addr", o_addr, mpc);
    chk("out_valid", {63'h0, o_valid}, {63'h0, exp_valid});
    chk("out_pc", o_pc, h.pc);
    chk("out_inst", {32'h0, o_inst}, {32'h0, h.inst});
    chk("out_exc", {63'h0, o_exc}, {63'h0, h.exc});
    @(posedge clk);
    if (!r) begin
      mq.delete();
      mpc = RST_PC;
      mmode = 0;
    end else if (rv) begin
      mq.delete();
      mpc = rpc;
      mmode = (rpc % 4 == 0) ? 0 : 1;
    end else begin
      if (exp_pop) void'(mq.pop_front());
      if (exp_en) begin
        mq.push_back('{pc: mpc, inst: ram_inst(mpc), exc: 1'b0});
        mpc = mpc + 64'd4;
      end else if (mmode == 1) begin
        mq.push_back('{pc: mpc, inst: 32'h0, exc: 1'b1});
        mmode = 2;
      end
    end
    #1;
  endtask

  initial begin
    logic [63:0] rpc;
    // Reset, then stream with decode always ready.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("tp1_addr0", o_addr, 64'h8000_0000);
    step(1, 0, 0, 1);
    chk("tp1_addr1", o_addr, 64'h8000_0004);
    chk("tp1_pc0", o_pc, 64'h8000_0000);
    chk("tp1_inst0", {32'h0, o_inst}, 64'h13);
    step(1, 0, 0, 1);
    chk("tp1_pc1", o_pc, 64'h8000_0004);
    chk("tp1_inst1", {32'h0, o_inst}, 64'h0010_0093);
    chk("tp1_exc", {63'h0, o_exc}, 64'h0);

    // Back-pressure after reset: two fetches then stall.
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("bp_en_stalled", {63'h0, o_en}, 64'h0);
    chk("bp_pc_held", o_addr, 64'h8000_0008);
    step(1, 0, 0, 1);
    chk("bp_en_resume", {63'h0, o_en}, 64'h1);
    chk("bp_head0", o_pc, 64'h8000_0000);
    step(1, 0, 0, 1);
    chk("bp_head1", o_pc, 64'h8000_0004);

    // Full queue streaming with pop every cycle.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 1);
      chk("full_stream_en", {63'h0, o_en}, 64'h1);
    end

    // Redirect with a full queue.
    step(1, 0, 0, 0);
    step(1, 1, 64'h8000_0100, 0);
    step(1, 0, 0, 1);
    chk("redir_valid0", {63'h0, o_valid}, 64'h0);
    chk("redir_addr", o_addr, 64'h8000_0100);
    step(1, 0, 0, 1);
    chk("redir_head", o_pc, 64'h8000_0100);

    // Misaligned redirect, halt, then resume via aligned redirect.
    step(1, 1, 64'h8000_0102, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("exc_pc", o_pc, 64'h8000_0102);
    chk("exc_flag", {63'h0, o_exc}, 64'h1);
    chk("exc_inst", {32'h0, o_inst}, 64'h0);
    step(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1);
      chk("halt_en", {63'h0, o_en}, 64'h0);
    end
    step(1, 1, 64'h8000_0200, 1);
    step(1, 0, 0, 1);
    chk("resume_addr", o_addr, 64'h8000_0200);
    chk("resume_en", {63'h0, o_en}, 64'h1);

    // Reset while halted with the marker waiting.
    step(1, 1, 64'h8000_0306, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_halt_valid", {63'h0, o_valid}, 64'h0);
    chk("rst_halt_en", {63'h0, o_en}, 64'h0);
    step(1, 0, 0, 1);
    chk("rst_halt_addr", o_addr, 64'h8000_0000);
    chk("rst_halt_en1", {63'h0, o_en}, 64'h1);

    // PC wrap at the top of the address space.
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("wrap_addr", o_addr, 64'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        1: rpc = 64'h8000_0000 + 64'($urandom_range(0, 255));
        default: rpc = 64'h8000_0000 + 64'({$urandom_range(0, 1023), 2'b00});
      endcase
      step($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 6, rpc,
           $urandom_range(0, 99) < 65);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
